// File: rtl/csa_accumulator.sv
// ---------------------------------------------------------------------------
// csa_accumulator
//
// Streaming multi-operand accumulator. Operands arrive one per cycle and are
// folded into a redundant carry-save total (sum_q / carry_q), so the
// per-operand loop is a single full-adder level with no carry chain. When a
// group closes, a single carry-propagate add resolves the total, which is then
// presented on the output port until it is taken.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid and ready are both 1. Ready and valid here come straight from state,
// with no combinational path from in_valid or out_ready.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   in_valid      operand valid
//   in_ready      block can accept an operand (state == ACCUM)
//   in_data       operand, WIDTH bits, sign- or zero-extended per SIGNED
//   in_last       marks the final operand of a group
//   out_valid     resolved result valid (state == OUTPUT)
//   out_ready     downstream accepts the result
//   out_data      resolved group sum, modulo 2^ACC_WIDTH
//   out_count     number of operands in the group
//   out_overflow  group was force-closed at MAX_TERMS without in_last
//   dbg_state     current FSM state (ACCUM=0, RESOLVE=1, OUTPUT=2)
// ---------------------------------------------------------------------------
module csa_accumulator #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 32,
  parameter int SIGNED    = 1,
  parameter int MAX_TERMS = 256
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WIDTH-1:0]                   in_data,
  input  logic                               in_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [ACC_WIDTH-1:0]               out_data,
  output logic [$clog2(MAX_TERMS+1)-1:0]     out_count,
  output logic                               out_overflow,
  output logic [1:0]                         dbg_state
);

  localparam int CW = $clog2(MAX_TERMS + 1);

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] sum_q, carry_q;
  logic [CW-1:0]        count_q;
  logic                 ovf_q;

  logic [ACC_WIDTH-1:0] x;
  logic                 accept;
  logic                 at_limit;
  logic                 close_group;

  // Operand extension to accumulator width.
  if (ACC_WIDTH > WIDTH && SIGNED != 0) begin : g_sext
    assign x = {{(ACC_WIDTH-WIDTH){in_data[WIDTH-1]}}, in_data};
  end else if (ACC_WIDTH > WIDTH) begin : g_zext
    assign x = {{(ACC_WIDTH-WIDTH){1'b0}}, in_data};
  end else begin : g_same
    assign x = in_data;
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == OUTPUT);
  assign dbg_state = state_q;

  assign accept      = in_valid & in_ready;
  assign at_limit    = (int'(count_q) + 1 == MAX_TERMS);
  assign close_group = accept & (in_last | at_limit);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (close_group) state_d = RESOLVE;
      RESOLVE: state_d = OUTPUT;
      OUTPUT:  if (out_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q        <= '0;
      carry_q      <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      out_data     <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            // 3:2 compression; the carry out of the MSB is dropped (mod 2^N).
            sum_q   <= sum_q ^ carry_q ^ x;
            carry_q <= ((sum_q & carry_q) | (sum_q & x) | (carry_q & x)) << 1;
            count_q <= count_q + 1'b1;
            // in_last wins over the limit when both hold on the same operand.
            if (close_group) ovf_q <= ~in_last;
          end
        end
        RESOLVE: begin
          out_data     <= sum_q + carry_q;
          out_count    <= count_q;
          out_overflow <= ovf_q;
        end
        OUTPUT: begin
          // out_* are left holding the last result after the handshake.
          if (out_ready) begin
            sum_q   <= '0;
            carry_q <= '0;
            count_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// ---------------------------------------------------------------------------
// tb_csa_accumulator
//
// Directed bench over three instances sharing clk/rst:
//   u0: SIGNED=0, ACC_WIDTH=32, MAX_TERMS=256
//   u1: SIGNED=1, ACC_WIDTH=32, MAX_TERMS=4
//   u2: SIGNED=0, ACC_WIDTH=16, MAX_TERMS=2
// Inputs are driven on the falling edge / just after the rising edge; outputs
// are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_csa_accumulator;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- per-instance signals ----------------
  logic        iv[3];
  logic        il[3];
  logic        ordy[3];
  logic [15:0] id[3];
  logic        irdy[3];
  logic        ov[3];
  logic        oovf[3];
  logic [31:0] od[3];
  logic [8:0]  oc[3];
  logic [1:0]  st[3];

  logic [31:0] od0, od1;
  logic [15:0] od2;
  logic [8:0]  oc0;
  logic [2:0]  oc1;
  logic [1:0]  oc2;

  assign od[0] = od0;
  assign od[1] = od1;
  assign od[2] = {16'h0000, od2};
  assign oc[0] = oc0;
  assign oc[1] = {6'd0, oc1};
  assign oc[2] = {7'd0, oc2};

  csa_accumulator #(.WIDTH(16), .ACC_WIDTH(32), .SIGNED(0), .MAX_TERMS(256)) u0 (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(irdy[0]), .in_data(id[0]), .in_last(il[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od0), .out_count(oc0),
    .out_overflow(oovf[0]), .dbg_state(st[0])
  );

  csa_accumulator #(.WIDTH(16), .ACC_WIDTH(32), .SIGNED(1), .MAX_TERMS(4)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(irdy[1]), .in_data(id[1]), .in_last(il[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od1), .out_count(oc1),
    .out_overflow(oovf[1]), .dbg_state(st[1])
  );

  csa_accumulator #(.WIDTH(16), .ACC_WIDTH(16), .SIGNED(0), .MAX_TERMS(2)) u2 (
    .clk(clk), .rst(rst),
    .in_valid(iv[2]), .in_ready(irdy[2]), .in_data(id[2]), .in_last(il[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od2), .out_count(oc2),
    .out_overflow(oovf[2]), .dbg_state(st[2])
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input int s);
    int n = 0;
    while (irdy[s] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input int s, input logic [15:0] d, input logic last);
    @(negedge clk);
    wait_ready(s);
    iv[s] = 1'b1;
    id[s] = d;
    il[s] = last;
    @(posedge clk);
    #1;
    iv[s] = 1'b0;
    il[s] = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
  endtask

  // Expected result comes from exp_q; hold = cycles of out_ready=0 after valid.
  task automatic get_result(input int s, input string tag, input logic [8:0] ec,
                            input logic eo, input int hold);
    int n = 0;
    logic [31:0] ed;
    ed = exp_q.pop_front();
    @(negedge clk);
    while (ov[s] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check({tag, "_valid_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_data"}, od[s], ed);
    check({tag, "_count"}, {23'd0, oc[s]}, {23'd0, ec});
    check({tag, "_ovf"}, {31'd0, oovf[s]}, {31'd0, eo});
    check({tag, "_in_ready"}, {31'd0, irdy[s]}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, {31'd0, ov[s]}, 32'd1);
      check({tag, "_hold_data"}, od[s], ed);
      check({tag, "_hold_count"}, {23'd0, oc[s]}, {23'd0, ec});
      check({tag, "_hold_in_ready"}, {31'd0, irdy[s]}, 32'd0);
    end
    ordy[s] = 1'b1;
    @(posedge clk);
    #1;
    ordy[s] = 1'b0;
    @(negedge clk);
    check({tag, "_valid_drop"}, {31'd0, ov[s]}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, irdy[s]}, 32'd1);
  endtask

  task automatic pulse_reset(input int s, input string tag);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_during_valid"}, {31'd0, ov[s]}, 32'd0);
    check({tag, "_during_data"}, od[s], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check({tag, "_after_valid"}, {31'd0, ov[s]}, 32'd0);
    check({tag, "_after_data"}, od[s], 32'd0);
    check({tag, "_after_count"}, {23'd0, oc[s]}, 32'd0);
    check({tag, "_after_ready"}, {31'd0, irdy[s]}, 32'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; il[i] = 1'b0; ordy[i] = 1'b0; id[i] = 16'h0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);

    // Reset state on every instance.
    for (int s = 0; s < 3; s++) begin
      check("rst_valid", {31'd0, ov[s]}, 32'd0);
      check("rst_data", od[s], 32'd0);
      check("rst_count", {23'd0, oc[s]}, 32'd0);
      check("rst_ovf", {31'd0, oovf[s]}, 32'd0);
      check("rst_ready", {31'd0, irdy[s]}, 32'd1);
    end

    // Unsigned group with an idle gap, plus latency check.
    send(0, 16'hFFFF, 1'b0);
    send(0, 16'hFFFF, 1'b0);
    idle_cycle();
    send(0, 16'h0001, 1'b1);
    @(negedge clk);
    check("uns_lat_resolve_valid", {31'd0, ov[0]}, 32'd0);
    check("uns_lat_resolve_ready", {31'd0, irdy[0]}, 32'd0);
    @(negedge clk);
    check("uns_lat_output_valid", {31'd0, ov[0]}, 32'd1);
    exp_q.push_back(32'h0001FFFF);
    get_result(0, "uns", 9'd3, 1'b0, 0);

    // Signed groups.
    send(1, 16'hFFFF, 1'b0);
    send(1, 16'h0005, 1'b1);
    exp_q.push_back(32'h00000004);
    get_result(1, "sgn_a", 9'd2, 1'b0, 0);
    send(1, 16'h8000, 1'b1);
    exp_q.push_back(32'hFFFF8000);
    get_result(1, "sgn_b", 9'd1, 1'b0, 0);

    // Backpressure, then a fresh group to show no residue.
    send(1, 16'h0012, 1'b0);
    send(1, 16'h0034, 1'b1);
    exp_q.push_back(32'h00000046);
    get_result(1, "bp", 9'd2, 1'b0, 5);
    send(1, 16'h0007, 1'b1);
    exp_q.push_back(32'h00000007);
    get_result(1, "bp_next", 9'd1, 1'b0, 0);

    // Forced close at MAX_TERMS=4: six ones, in_last only on the sixth.
    for (int i = 0; i < 4; i++) send(1, 16'h0001, 1'b0);
    exp_q.push_back(32'h00000004);
    get_result(1, "force_a", 9'd4, 1'b1, 0);
    send(1, 16'h0001, 1'b0);
    send(1, 16'h0001, 1'b1);
    exp_q.push_back(32'h00000002);
    get_result(1, "force_b", 9'd2, 1'b0, 0);

    // Wrap at ACC_WIDTH=16 with in_last on the limit operand.
    send(2, 16'h8000, 1'b0);
    send(2, 16'h8000, 1'b1);
    exp_q.push_back(32'h00000000);
    get_result(2, "wrap", 9'd2, 1'b0, 0);

    // Reset mid-group.
    send(0, 16'h0010, 1'b0);
    send(0, 16'h0020, 1'b0);
    pulse_reset(0, "rst_mid");
    send(0, 16'h0003, 1'b1);
    exp_q.push_back(32'h00000003);
    get_result(0, "rst_mid_next", 9'd1, 1'b0, 0);

    // Reset while a result is pending in OUTPUT.
    send(0, 16'h0005, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("rst_out_pending_valid", {31'd0, ov[0]}, 32'd1);
    check("rst_out_pending_data", od[0], 32'h00000005);
    pulse_reset(0, "rst_out");
    send(0, 16'h0009, 1'b1);
    exp_q.push_back(32'h00000009);
    get_result(0, "rst_out_next", 9'd1, 1'b0, 0);

    check("exp_q_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csa_accumulator.md
# csa_accumulator

Parametrised streaming multi-operand accumulator for the NPU datapath. It takes one operand per cycle through a valid/ready handshake and keeps the running total in redundant carry-save form (sum and carry registers), so no carry chain sits in the per-operand loop. When a group ends, one carry-propagate add resolves the total, and the result is presented on a valid/ready output port. It sits after the partial-product and MAC stages and generalises the 16-bit 3:2 carry-save stage: it adds width, signedness, grouping and backpressure.

## Interface
- WIDTH, 16: operand width in bits.
- ACC_WIDTH, 32: accumulator and result width. Must be ≥ WIDTH.
- SIGNED, 1: 1 = operands sign-extended to ACC_WIDTH; 0 = zero-extended.
- MAX_TERMS, 256: maximum operands per group. Must be ≥ 1.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand.
- in_data  input  WIDTH  operand.
- in_last  input  1  marks the final operand of a group.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  ACC_WIDTH  resolved group sum.
- out_count  output  $clog2(MAX_TERMS+1)  number of operands in the group.
- out_overflow  output  1  group was force-closed at MAX_TERMS without in_last.

## Operation
- States: ACCUM, RESOLVE, OUTPUT.
- Reset state is ACCUM. Reset values:
  - sum_q, carry_q, count_q = 0.
  - out_valid = 0, out_data = 0, out_count = 0, out_overflow = 0.
  - in_ready = 1 from the first cycle after rst is released.
- ACCUM:
  - in_ready = 1.
  - On accept (in_valid & in_ready), with x = extend(in_data):
    - sum_q ← sum_q ^ carry_q ^ x.
    - carry_q ← (majority(sum_q, carry_q, x) << 1), truncated to ACC_WIDTH.
    - count_q ← count_q + 1.
  - Accepted with in_last = 1 → RESOLVE, ovf_q ← 0.
  - Accepted with in_last = 0 and count_q + 1 == MAX_TERMS → RESOLVE, ovf_q ← 1.
  - When both conditions hold, in_last wins: ovf_q ← 0.
  - Cycles without in_valid leave all state unchanged.
- RESOLVE (exactly one cycle, in_ready = 0):
  - out_data ← (sum_q + carry_q) mod 2^ACC_WIDTH.
  - out_count ← count_q; out_overflow ← ovf_q.
  - Next state OUTPUT.
- OUTPUT:
  - in_ready = 0; out_valid = 1.
  - out_data, out_count and out_overflow are held stable until the handshake.
  - On out_valid & out_ready: sum_q, carry_q, count_q ← 0; out_valid ← 0; next state ACCUM.
  - out_data keeps its last value after the handshake (don't-care while out_valid = 0).
- Arithmetic is modulo 2^ACC_WIDTH. The carry bit shifted out of the MSB is discarded. No saturation.
- There is no bypass: in_ready is 0 throughout RESOLVE and OUTPUT, even when out_ready = 1.
- rst takes priority over every event. Reset mid-group or mid-OUTPUT discards the partial sum and the pending result with no output.

## Timing
- Throughput: one operand per cycle in ACCUM.
- Latency: last operand accepted at edge E0 → result registered at edge E1 → out_valid = 1 in the cycle after E1.
- Output handshake at edge E2 → in_ready = 1 in the cycle after E2.
- Minimum group turnaround: 3 cycles (last accept, RESOLVE, OUTPUT with out_ready = 1).
- in_ready, out_valid and the out_* fields are driven directly from registers/state. No combinational path from in_valid or out_ready to any output.
- The per-cycle critical path is one full-adder level plus the enables. The only carry-propagate adder is in RESOLVE.

## Test plan
- Unsigned (SIGNED=0, WIDTH=16, ACC_WIDTH=32): operands 0xFFFF, 0xFFFF, 0x0001 (last) with one idle in_valid gap → out_data 0x0001FFFF, out_count 3, out_overflow 0; out_valid 2 edges after the last accept.
- Signed (SIGNED=1): 0xFFFF, 0x0005 (last) → out_data 0x00000004. Then a 1-operand group 0x8000 (last) → out_data 0xFFFF8000, out_count 1.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid rises.
  - out_data, out_count and out_valid stay stable; in_ready stays 0.
  - After the handshake, in_ready = 1 next cycle.
  - Next group 0x0007 (last) → out_data 0x00000007, confirming no residue from the prior group.
- Forced close (MAX_TERMS=4): feed six operands of 0x0001, with in_last only on the sixth.
  - First result: 0x00000004, out_count 4, out_overflow 1.
  - Second result: 0x00000002, out_count 2, out_overflow 0.
- Wrap and last-at-limit (ACC_WIDTH=16, SIGNED=0, MAX_TERMS=2): 0x8000, 0x8000 (last) → out_data 0x0000, out_overflow 0.
- Reset mid-operation: accept 0x0010 and 0x0020, then pulse rst for one cycle.
  - During and after reset: out_valid 0, out_data 0, count cleared.
  - Group 0x0003 (last) → out_data 3, out_count 1.
  - Repeat with rst asserted during OUTPUT → the result is dropped and out_valid falls.
